hazard_scoreboard: RTL

Register-hazard tracker on the consumer side of the EX/MEM/WB result paths. It decides when the ID-stage instruction may not advance because a needed source value cannot be bypassed. It covers:
- load-use hazards;
- pending results of the variable-latency multicycle unit (mul/div), tracked in a 32-entry scoreboard.

Its stall and bubble outputs drive the PC, IF/ID and ID/EX pipeline registers, alongside the operand forwarding mux selects.

---
 rtl/hazard_scoreboard.sv | 113 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall generator for load-use and multicycle
// (mul/div) register hazards, backed by a 32-entry pending-result scoreboard.
//
// Handshake: issue_valid and mc_done are single-cycle event strobes with no
// ready/backpressure; each asserted cycle is exactly one event, qualified by
// issue_rd / mc_rd in the same cycle.
module hazard_scoreboard #(
  parameter  int MAX_OUT = 4,
  parameter  int CNT_W   = 16,
  localparam int OUT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_regwrite,
  input  logic [4:0]       id_rd,
  input  logic             id_is_mc,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             mc_done,
  input  logic [4:0]       mc_rd,
  output logic             stall,
  output logic             bubble,
  output logic [31:0]      pending,
  output logic [OUT_W-1:0] out_cnt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             sb_err
);

  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUT);

  logic [31:0]      pending_q, pending_d;
  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             sb_err_q, sb_err_d;

  logic             clr_hit, set_req, ovf, set_ok;
  logic [OUT_W:0]   eff_cnt;
  logic             rs1_en, rs2_en, hit1, hit2, load_use, waw, structural;

  // Scoreboard event decode: accepted issue, valid completion, overflow drop.
  always_comb begin
    clr_hit = mc_done && pending_q[mc_rd];
    set_req = issue_valid && (issue_rd != 5'd0);
    ovf     = issue_valid && (out_cnt_q == MAX_CNT) && !clr_hit;
    set_ok  = set_req && !ovf;
    // Count as it will stand after this edge's accepted set/clear.
    eff_cnt = {1'b0, out_cnt_q} + (OUT_W + 1)'(set_ok) - (OUT_W + 1)'(clr_hit);
  end

  // Hazard terms; a completing result is readable this cycle (write-before-read
  // regfile), so a same-cycle mc_done for the register removes its hazard.
  always_comb begin
    rs1_en     = id_use_rs1 && (id_rs1 != 5'd0);
    rs2_en     = id_use_rs2 && (id_rs2 != 5'd0);
    hit1       = rs1_en &&
                 ((pending_q[id_rs1] && !(mc_done && mc_rd == id_rs1)) ||
                  (issue_valid && issue_rd == id_rs1));
    hit2       = rs2_en &&
                 ((pending_q[id_rs2] && !(mc_done && mc_rd == id_rs2)) ||
                  (issue_valid && issue_rd == id_rs2));
    load_use   = id_ex_memread && (id_ex_rd != 5'd0) &&
                 ((rs1_en && id_rs1 == id_ex_rd) || (rs2_en && id_rs2 == id_ex_rd));
    waw        = id_regwrite && (id_rd != 5'd0) &&
                 ((pending_q[id_rd] && !(mc_done && mc_rd == id_rd)) ||
                  (issue_valid && issue_rd == id_rd));
    structural = id_is_mc && (eff_cnt == (OUT_W + 1)'(MAX_OUT));
    // While in reset the scoreboard is being discarded; only load-use matters.
    stall      = load_use || (!rst && (hit1 || hit2 || waw || structural));
    bubble     = stall;
  end

  // Next-state for scoreboard, outstanding count, stall counter and error flag.
  always_comb begin
    pending_d      = pending_q;
    out_cnt_d      = out_cnt_q;
    stall_cycles_d = stall_cycles_q;
    sb_err_d       = sb_err_q;
    if (clr_hit) pending_d[mc_rd] = 1'b0;
    // Applied after the clear so that a same-rd set wins.
    if (set_ok) pending_d[issue_rd] = 1'b1;
    if (set_ok && !(clr_hit && mc_rd == issue_rd)) out_cnt_d = out_cnt_d + 1'b1;
    if (clr_hit && !(set_ok && issue_rd == mc_rd)) out_cnt_d = out_cnt_d - 1'b1;
    if ((mc_done && !pending_q[mc_rd]) || ovf) sb_err_d = 1'b1;
    if (stall && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= '0;
      out_cnt_q      <= '0;
      stall_cycles_q <= '0;
      sb_err_q       <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      out_cnt_q      <= out_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      sb_err_q       <= sb_err_d;
    end
  end

  assign pending      = pending_q;
  assign out_cnt      = out_cnt_q;
  assign stall_cycles = stall_cycles_q;
  assign sb_err       = sb_err_q;

endmodule
